// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the MEM-stage data-memory access path.
//   - access size encodings (MEM_BYTE/HALF/WORD; 2'b11 behaves as word)
//   - exception codes reported to MEM/WB
//   - access FSM state enum
//   - request struct carried from the launch cycle into BUSY
//   - helpers for size normalisation and alignment checking
package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_BUSERR   = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Everything the bus and the load aligner need, frozen while BUSY.
  // addr keeps the full byte address (low bits select the lane and
  // feed the bad-address register).
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
  } mem_req_t;

  // Size 2'b11 is reserved and behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? MEM_WORD : size;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    return ((size == MEM_HALF) && off[0]) ||
           ((size == MEM_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load lane select and extension.
// Also intended for the cache-fill path, so it has no state.
//   rdata     in  32  raw bus word
//   addr      in  2   byte offset within the word
//   size      in  2   MEM_BYTE / MEM_HALF / otherwise word
//   is_signed in  1   1 = sign-extend, 0 = zero-extend
//   data      out 32  aligned, extended load value
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[8*addr +: 8];
    lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      MEM_BYTE: data = {{24{is_signed & lane_b[7]}}, lane_b};
      MEM_HALF: data = {{16{is_signed & lane_h[15]}}, lane_h};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access controller.
// Turns EX/MEM load/store control into a req/ack bus transaction, stalls
// the pipeline while it is outstanding and hands aligned load data plus an
// exception code to MEM/WB in the DONE cycle.
//   clk, reset            clock / async active-high reset
//   IALUOut, IWriteData   effective address and store data from EX/MEM
//   ICMemRead/Write/Size/Signed  access control (R&W together = write)
//   OMemData, OExcept, OBadAddr  registered results, valid in DONE
//   OStall                combinational stall to the hazard unit
//   bus_*                 req/ack data bus (addr word-aligned, byte lanes)
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IALUOut,
  input  logic [31:0] IWriteData,
  input  logic        ICMemRead,
  input  logic        ICMemWrite,
  input  logic [1:0]  ICMemSize,
  input  logic        ICMemSigned,
  output logic [31:0] OMemData,
  output logic        OStall,
  output logic [1:0]  OExcept,
  output logic [31:0] OBadAddr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  mem_req_t    live, held, cur;
  logic        access, misalign;
  logic        stall, req;
  logic        launch, bad_en;
  logic [1:0]  exc_nxt;
  logic [31:0] data_nxt, aligned;

  assign access   = ICMemRead | ICMemWrite;
  assign misalign = is_misaligned(norm_size(ICMemSize), IALUOut[1:0]);

  // Request as seen straight from EX/MEM, used in the launch cycle.
  always_comb begin
    live       = '0;
    live.addr  = IALUOut;
    live.we    = ICMemWrite;
    live.size  = norm_size(ICMemSize);
    live.sgn   = ICMemSigned;
    live.be    = 4'b1111;
    live.wdata = IWriteData;
    case (live.size)
      MEM_BYTE: live.wdata = {4{IWriteData[7:0]}};
      MEM_HALF: live.wdata = {2{IWriteData[15:0]}};
      default:  live.wdata = IWriteData;
    endcase
    if (ICMemWrite) begin
      case (live.size)
        MEM_BYTE: live.be = 4'b0001 << IALUOut[1:0];
        MEM_HALF: live.be = 4'b0011 << IALUOut[1:0];
        default:  live.be = 4'b1111;
      endcase
    end
  end

  // BUSY drives the bus from the captured copy so nothing can wiggle
  // even if the upstream register is disturbed.
  assign cur = (state == ST_BUSY) ? held : live;

  mem_load_align u_align (
    .rdata     (bus_rdata),
    .addr      (cur.addr[1:0]),
    .size      (cur.size),
    .is_signed (cur.sgn),
    .data      (aligned)
  );

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    req       = 1'b0;
    launch    = 1'b0;
    bad_en    = 1'b0;
    exc_nxt   = EXC_NONE;
    data_nxt  = '0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          stall = 1'b1;
          if (misalign) begin
            state_nxt = ST_DONE;
            exc_nxt   = EXC_MISALIGN;
            bad_en    = 1'b1;
          end else begin
            req = 1'b1;
            if (bus_err) begin
              state_nxt = ST_DONE;
              exc_nxt   = EXC_BUSERR;
              bad_en    = 1'b1;
            end else if (bus_ack) begin
              state_nxt = ST_DONE;
              data_nxt  = cur.we ? 32'h0 : aligned;
            end else begin
              state_nxt = ST_BUSY;
              launch    = 1'b1;
            end
          end
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        req   = 1'b1;
        // Priority: err over ack over timeout.
        if (bus_err) begin
          state_nxt = ST_DONE;
          exc_nxt   = EXC_BUSERR;
          bad_en    = 1'b1;
        end else if (bus_ack) begin
          state_nxt = ST_DONE;
          data_nxt  = cur.we ? 32'h0 : aligned;
        end else if (cnt + 8'd1 == TO_LIMIT) begin
          state_nxt = ST_DONE;
          exc_nxt   = EXC_TIMEOUT;
          bad_en    = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Counts completed BUSY cycles; the timeout compare looks one ahead so
  // the last BUSY cycle is the TIMEOUT_CYC-th one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (state == ST_BUSY) cnt <= cnt + 8'd1;
    else                       cnt <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       held <= '0;
    else if (launch) held <= live;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      OMemData <= '0;
      OExcept  <= EXC_NONE;
      OBadAddr <= '0;
    end else if (state_nxt == ST_DONE) begin
      OMemData <= data_nxt;
      OExcept  <= exc_nxt;
      if (bad_en) OBadAddr <= cur.addr;
    end else if (state == ST_DONE) begin
      OExcept <= EXC_NONE;
    end
  end

  // Reset gating makes bus_req/OStall drop without waiting for an edge.
  assign OStall    = stall & ~reset;
  assign bus_req   = req & ~reset;
  assign bus_we    = bus_req & cur.we;
  assign bus_be    = bus_req ? cur.be : 4'b0000;
  assign bus_addr  = {cur.addr[31:2], 2'b00};
  assign bus_wdata = cur.wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT_CYC = 4).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IALUOut, IWriteData;
  logic        ICMemRead, ICMemWrite, ICMemSigned;
  logic [1:0]  ICMemSize;
  logic [31:0] OMemData, OBadAddr;
  logic        OStall;
  logic [1:0]  OExcept;
  logic        bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int checks   = 0;
  int failures = 0;
  int stalls, reqs;
  bit stable;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset),
    .IALUOut(IALUOut), .IWriteData(IWriteData),
    .ICMemRead(ICMemRead), .ICMemWrite(ICMemWrite),
    .ICMemSize(ICMemSize), .ICMemSigned(ICMemSigned),
    .OMemData(OMemData), .OStall(OStall), .OExcept(OExcept),
    .OBadAddr(OBadAddr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat);
    ICMemRead = rd; ICMemWrite = wr; ICMemSize = sz; ICMemSigned = sg;
    IALUOut = a; IWriteData = wd; bus_rdata = rdat;
  endtask

  // Starts right after a posedge with the op applied; returns sampling the
  // DONE cycle. ack/err are asserted in stall-cycle index k (0 = launch).
  task automatic run_txn(input int ack_at, input int err_at,
                         input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input logic e_we,
                         output int n_stall, output int n_req, output bit ok);
    bit done = 0;
    n_stall = 0; n_req = 0; ok = 1;
    for (int k = 0; k < 40; k++) begin
      bus_ack = (k == ack_at);
      bus_err = (k == err_at);
      @(negedge clk);
      if (!OStall) begin done = 1; break; end
      n_stall++;
      if (bus_req) begin
        n_req++;
        if (bus_addr !== e_addr || bus_be !== e_be || bus_wdata !== e_wd || bus_we !== e_we)
          ok = 0;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("txn_cycle_bound", 32'd0, 32'd1);
  endtask

  // EX/MEM advances on the DONE edge: next instruction is a non-memory op.
  task automatic finish_txn();
    @(posedge clk); #1;
    bus_ack = 0; bus_err = 0;
    set_op(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1; bus_ack = 0; bus_err = 0;
    set_op(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h0);
    #12;
    chk("rst_omemdata", OMemData, 32'h0);
    chk("rst_oexcept", {30'd0, OExcept}, 32'h0);
    chk("rst_obadaddr", OBadAddr, 32'h0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'h0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'h0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'h0);
    reset = 0;
    @(posedge clk); #1;

    // Non-memory instruction: no stall, no request.
    @(negedge clk);
    chk("nomem_stall", {31'd0, OStall}, 32'h0);
    chk("nomem_req", {31'd0, bus_req}, 32'h0);
    @(posedge clk); #1;

    // Signed byte load at 0x103, ack in first request cycle.
    set_op(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80AABBCC);
    run_txn(0, -1, 32'h100, 4'b1111, 32'h0, 1'b0, stalls, reqs, stable);
    chk("lb_stalls", stalls, 1);
    chk("lb_bus_fields", {31'd0, stable}, 32'h1);
    chk("lb_data", OMemData, 32'hFFFFFF80);
    chk("lb_exc", {30'd0, OExcept}, 32'h0);
    finish_txn();

    // Half store at 0x202, ack after 3 BUSY cycles.
    set_op(0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF);
    run_txn(3, -1, 32'h200, 4'b1100, 32'hABCDABCD, 1'b1, stalls, reqs, stable);
    chk("sh_stalls", stalls, 4);
    chk("sh_reqs", reqs, 4);
    chk("sh_bus_stable", {31'd0, stable}, 32'h1);
    chk("sh_data", OMemData, 32'h0);
    chk("sh_exc", {30'd0, OExcept}, 32'h0);
    finish_txn();

    // Misaligned word load at 0x305.
    set_op(1, 0, 2'b10, 0, 32'h305, 32'h0, 32'h11111111);
    run_txn(-1, -1, 32'h0, 4'h0, 32'h0, 1'b0, stalls, reqs, stable);
    chk("mis_stalls", stalls, 1);
    chk("mis_reqs", reqs, 0);
    chk("mis_exc", {30'd0, OExcept}, 32'h1);
    chk("mis_badaddr", OBadAddr, 32'h305);
    chk("mis_data", OMemData, 32'h0);
    finish_txn();
    @(negedge clk);
    chk("mis_exc_cleared", {30'd0, OExcept}, 32'h0);
    @(posedge clk); #1;

    // Timeout: no ack/err, TIMEOUT_CYC = 4.
    set_op(1, 0, 2'b10, 0, 32'h400, 32'h0, 32'h22222222);
    run_txn(-1, -1, 32'h400, 4'b1111, 32'h0, 1'b0, stalls, reqs, stable);
    chk("to_stalls", stalls, 5);
    chk("to_exc", {30'd0, OExcept}, 32'h3);
    chk("to_data", OMemData, 32'h0);
    finish_txn();
    @(negedge clk);
    chk("to_idle_stall", {31'd0, OStall}, 32'h0);
    chk("to_exc_cleared", {30'd0, OExcept}, 32'h0);
    @(posedge clk); #1;

    // Unsigned half load at 0x602 (upper half), ack immediately.
    set_op(1, 0, 2'b01, 0, 32'h602, 32'h0, 32'h87654321);
    run_txn(0, -1, 32'h600, 4'b1111, 32'h0, 1'b0, stalls, reqs, stable);
    chk("lhu_data", OMemData, 32'h00008765);
    finish_txn();

    // Signed half load at 0x600 (lower half).
    set_op(1, 0, 2'b01, 1, 32'h600, 32'h0, 32'h0000F00D);
    run_txn(0, -1, 32'h600, 4'b1111, 32'h0, 1'b0, stalls, reqs, stable);
    chk("lh_data", OMemData, 32'hFFFFF00D);
    finish_txn();

    // Unsigned byte load lane 1.
    set_op(1, 0, 2'b00, 0, 32'h101, 32'h0, 32'h80AABBCC);
    run_txn(1, -1, 32'h100, 4'b1111, 32'h0, 1'b0, stalls, reqs, stable);
    chk("lbu_stalls", stalls, 2);
    chk("lbu_data", OMemData, 32'h000000BB);
    finish_txn();

    // Byte store lane 1: data must be zero after a store.
    set_op(0, 1, 2'b00, 0, 32'h701, 32'h12345655, 32'hFFFFFFFF);
    run_txn(0, -1, 32'h700, 4'b0010, 32'h55555555, 1'b1, stalls, reqs, stable);
    chk("sb_bus_fields", {31'd0, stable}, 32'h1);
    chk("sb_data", OMemData, 32'h0);
    finish_txn();

    // Read and write both high, size 11: word store.
    set_op(1, 1, 2'b11, 0, 32'h708, 32'hCAFEF00D, 32'h0);
    run_txn(0, -1, 32'h708, 4'b1111, 32'hCAFEF00D, 1'b1, stalls, reqs, stable);
    chk("sw11_bus_fields", {31'd0, stable}, 32'h1);
    chk("sw11_reqs", reqs, 1);
    finish_txn();

    // ack and err together in BUSY: err wins.
    set_op(1, 0, 2'b10, 0, 32'h500, 32'h0, 32'h11223344);
    run_txn(1, 1, 32'h500, 4'b1111, 32'h0, 1'b0, stalls, reqs, stable);
    chk("ackerr_stalls", stalls, 2);
    chk("ackerr_exc", {30'd0, OExcept}, 32'h2);
    chk("ackerr_data", OMemData, 32'h0);
    finish_txn();

    // err in the launch cycle.
    set_op(1, 0, 2'b10, 0, 32'h800, 32'h0, 32'h33333333);
    run_txn(-1, 0, 32'h800, 4'b1111, 32'h0, 1'b0, stalls, reqs, stable);
    chk("err0_stalls", stalls, 1);
    chk("err0_exc", {30'd0, OExcept}, 32'h2);
    finish_txn();

    // ack in the same cycle the counter reaches the limit: ack wins.
    set_op(1, 0, 2'b10, 0, 32'h504, 32'h0, 32'hDEADBEEF);
    run_txn(4, -1, 32'h504, 4'b1111, 32'h0, 1'b0, stalls, reqs, stable);
    chk("acktmo_stalls", stalls, 5);
    chk("acktmo_exc", {30'd0, OExcept}, 32'h0);
    chk("acktmo_data", OMemData, 32'hDEADBEEF);
    finish_txn();

    // Reset while BUSY: bus_req drops asynchronously, no DONE afterwards.
    set_op(1, 0, 2'b10, 0, 32'h900, 32'h0, 32'h44444444);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy_req_before", {31'd0, bus_req}, 32'h1);
    #2 reset = 1;
    #1;
    chk("rstbusy_req_async", {31'd0, bus_req}, 32'h0);
    chk("rstbusy_badaddr", OBadAddr, 32'h0);
    set_op(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rstbusy_no_stall", {31'd0, OStall}, 32'h0);
      chk("rstbusy_no_exc", {30'd0, OExcept}, 32'h0);
      chk("rstbusy_no_req", {31'd0, bus_req}, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access controller of the 5-stage pipeline. It sits between the EX/MEM register and the MEM/WB register. It turns load/store control from EX/MEM into a req/ack bus transaction with byte lanes, and stalls the pipeline while the bus is busy. It delivers aligned, sign/zero-extended load data (OMemData) and an exception code to the MEM/WB register.

## Interface
Parameters:
- TIMEOUT_CYC, 64: BUSY cycles without ack/err before the timeout exception; range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- IALUOut  in  32  effective address from EX/MEM.
- IWriteData  in  32  store data (rt) from EX/MEM.
- ICMemRead, ICMemWrite  in  1 each  access type; both high is treated as a write.
- ICMemSize  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- ICMemSigned  in  1  1 = sign-extend loads.
- OMemData  out  32  extended load data, to MEM/WB.
- OStall  out  1  to hazard unit; holds PC, IF/ID, ID/EX, EX/MEM and bubbles MEM/WB.
- OExcept  out  2  00 none, 01 misaligned, 10 bus error, 11 timeout; valid only in the DONE cycle.
- OBadAddr  out  32  faulting address, registered.
- bus_req, bus_we  out  1 each.
- bus_addr  out  32  IALUOut with bits [1:0] forced to 00.
- bus_be  out  4  byte enables.
- bus_wdata  out  32.
- bus_ack, bus_err  in  1 each.
- bus_rdata  in  32.

## Operation
- access = ICMemRead | ICMemWrite. misaligned = (half & addr[0]) | (word & addr[1:0]≠0).
- FSM states: IDLE, BUSY, DONE.
  - IDLE, no access: OStall=0, bus_req=0. Data passes through with zero added latency.
  - IDLE, access & misaligned: no bus request. OStall=1. Latch OBadAddr. Go to DONE with code 01.
  - IDLE, access & aligned: bus_req=1 (combinational) and OStall=1.
    - ack or err this cycle → DONE.
    - Otherwise → BUSY.
  - BUSY: bus_req=1, OStall=1, and all bus outputs held stable.
    - err → DONE, code 10.
    - ack → DONE, code 00; load data is captured.
    - Counter reaches TIMEOUT_CYC → DONE, code 11.
  - DONE: OStall=0 and bus_req=0. OExcept and OMemData are valid, and MEM/WB captures them at this edge. Next state is IDLE unconditionally; EX/MEM advances at the same edge, so the access is not re-issued.
- Byte enables and store data:
  - byte: be = 0001 << addr[1:0]; wdata = byte replicated ×4.
  - half: be = 0011 << addr[1:0]; wdata = half replicated ×2.
  - word: be = 1111; wdata = IWriteData.
  - Reads drive be = 1111.
- Load extraction: select the lane by addr[1:0] and size, then sign- or zero-extend per ICMemSigned.
- OMemData is 0 after a store, a faulting access, or a timeout.
- Simultaneous events:
  - err with ack: err wins.
  - ack in the same cycle the counter reaches TIMEOUT_CYC: ack wins.
- Reset mid-transaction: immediately IDLE. bus_req drops asynchronously. The transaction is abandoned and not retried.

## Timing
- Reset values: state IDLE, OMemData 0, OExcept 00, OBadAddr 0, counter 0, bus_req/bus_we 0, bus_be 0000.
- Non-memory instruction: 0 stall cycles.
- Memory access with ack in the first request cycle: 1 stall cycle, then DONE.
- Memory access with ack N cycles after the first request: N+1 stall cycles.
- Misaligned access: exactly 1 stall cycle.
- Timeout: TIMEOUT_CYC+1 stall cycles.
- OMemData, OExcept and OBadAddr are registered and update entering DONE. OExcept returns to 00 on leaving DONE.
- OStall is combinational from state and inputs. Counter: 8 bits, cleared in IDLE, increments in BUSY.

## Structure
- Package mem_pkg holds:
  - size encodings: MEM_BYTE, MEM_HALF, MEM_WORD.
  - exception codes: EXC_NONE, EXC_MISALIGN, EXC_BUSERR, EXC_TIMEOUT.
  - state enum.
- Sub-module mem_load_align (combinational): inputs rdata, addr[1:0], size and signed; output extended data. It is reused by any later cache fill path.

## Test plan
- Signed byte load: addr 0x103, bus_rdata 0x80AABBCC, ack on the first request cycle → bus_addr 0x100, OStall high for 1 cycle, OMemData 0xFFFFFF80, OExcept 00.
- Half store: addr 0x202, data 0x1234ABCD, ack after 3 BUSY cycles → be 1100, wdata 0xABCDABCD, OStall high for 4 cycles, bus outputs stable throughout.
- Misaligned word load at 0x305 → no bus_req, 1 stall cycle, OExcept 01, OBadAddr 0x305.
- No ack with TIMEOUT_CYC=4 → OStall high for 5 cycles, OExcept 11, then IDLE.
- ack and err together → OExcept 10, OMemData 0. ack in the same cycle as timeout → OExcept 00.
- Reset asserted in BUSY → bus_req low without waiting for a clock edge, state IDLE, and no DONE pulse after release.
